// File: rtl/alu_issue.sv
// Issues one operation to an external combinational ALU, waits SETTLE_CYCLES, then holds the result until consumed.
// Optional feature: define ALU_ISSUE_ZERO_FLAG_EN to add the registered rsp_zero flag.
module alu_issue #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  ,
  output logic        rsp_zero
`endif
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
  // a response transfers on a rising edge with rsp_valid && rsp_ready. Both ready
  // and valid outputs are decoded from state only.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Last decrement lands on zero: sample the settled ALU output now.
        if (cnt <= 4'd1) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 4'd0;
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      alu_op   <= 3'd0;
      rsp_data <= 32'd0;
    end else begin
      if (accept) begin
        alu_a  <= req_a;
        alu_b  <= req_b;
        alu_op <= req_op;
        cnt    <= SETTLE_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_data <= alu_c;
      end
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_zero <= 1'b0;
    end else if (capture) begin
      rsp_zero <= (alu_c == 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: instance 0 uses SETTLE_CYCLES=1, instance 1 uses SETTLE_CYCLES=3,
// each fed by a behavioural ALU; table vectors, hand-written corner sequences, random ops.
module tb_alu_issue;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_op;
  logic [1:0][31:0] alu_a;
  logic [1:0][31:0] alu_b;
  logic [1:0][2:0]  alu_op;
  logic [1:0][31:0] alu_c;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_data;
  logic [1:0]       busy;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic [1:0]       rsp_zero;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  // Reference ALU semantics straight from the opcode list.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a >> b[4:0];
      default: return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  function automatic int settle(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign alu_c[g] = alu_f(alu_a[g], alu_b[g], alu_op[g]);
    alu_issue #(.SETTLE_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_a     (req_a[g]),
      .req_b     (req_b[g]),
      .req_op    (req_op[g]),
      .alu_a     (alu_a[g]),
      .alu_b     (alu_b[g]),
      .alu_op    (alu_op[g]),
      .alu_c     (alu_c[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .busy      (busy[g])
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      ,
      .rsp_zero  (rsp_zero[g])
`endif
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  // Driver + scoreboard: issue one op, check issue, latency, result, hold, release.
  task automatic do_op(input int g, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input int hold);
    logic [31:0] expv;
    int n;
    expv = exp_q.pop_front();
    req_a[g] = a;
    req_b[g] = b;
    req_op[g] = op;
    req_valid[g] = 1'b1;
    n = 0;
    while (!req_ready[g] && n < 20) begin
      step();
      n++;
    end
    check1("req_ready_idle", req_ready[g], 1'b1);
    step();
    req_valid[g] = 1'b0;
    check32("alu_a_issued", alu_a[g], a);
    check32("alu_b_issued", alu_b[g], b);
    check32("alu_op_issued", 32'(alu_op[g]), 32'(op));
    check1("busy_after_accept", busy[g], 1'b1);
    n = 0;
    while (!rsp_valid[g] && n < 20) begin
      step();
      n++;
    end
    check32("latency", 32'(n), 32'(settle(g)));
    check32("rsp_data", rsp_data[g], expv);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check1("rsp_zero", rsp_zero[g], expv == 32'd0);
`endif
    repeat (hold) begin
      step();
      check1("rsp_valid_hold", rsp_valid[g], 1'b1);
      check32("rsp_data_hold", rsp_data[g], expv);
    end
    rsp_ready[g] = 1'b1;
    step();
    rsp_ready[g] = 1'b0;
    check1("rsp_valid_after_ack", rsp_valid[g], 1'b0);
    check1("req_ready_after_ack", req_ready[g], 1'b1);
    check32("alu_a_kept", alu_a[g], a);
  endtask

  initial begin
    int pulses;
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;

    tbl[0] = '{32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000};
    tbl[1] = '{32'h00000000, 32'h00000001, 3'b001, 32'hFFFFFFFF};
    tbl[2] = '{32'h80000000, 32'h00000004, 3'b101, 32'hF8000000};
    tbl[3] = '{32'h80000000, 32'h00000004, 3'b100, 32'h08000000};
    tbl[4] = '{32'h0000F0F0, 32'h00000F0F, 3'b010, 32'h00000000};
    tbl[5] = '{32'h0000F0F0, 32'h00000F0F, 3'b011, 32'h0000FFFF};
    tbl[6] = '{32'h80000000, 32'h00000004, 3'b110, 32'hF8000000};
    tbl[7] = '{32'h80000000, 32'h00000001, 3'b111, 32'hC0000000};
    tbl[8] = '{32'h00000005, 32'h00000005, 3'b001, 32'h00000000};

    // Reset values while reset is held, before any clock edge.
    #1 reset = 1'b1;
    #2;
    for (int g = 0; g < 2; g++) begin
      check1("rst_rsp_valid", rsp_valid[g], 1'b0);
      check1("rst_busy", busy[g], 1'b0);
      check32("rst_alu_a", alu_a[g], 32'd0);
      check32("rst_rsp_data", rsp_data[g], 32'd0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      check1("rst_rsp_zero", rsp_zero[g], 1'b0);
`endif
    end
    step();
    @(negedge clk) reset = 1'b0;
    step();
    check1("req_ready_after_reset", req_ready[0], 1'b1);

    // Table vectors on the single-cycle instance.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(tbl[i].exp);
      do_op(0, tbl[i].a, tbl[i].b, tbl[i].op, i % 3);
    end

    // Back-pressure: stall in RESP while a new request is held.
    req_a[0] = 32'h12345678; req_b[0] = 32'h0000000F; req_op[0] = 3'b000;
    req_valid[0] = 1'b1;
    step();
    req_a[0] = 32'hAAAA0000; req_b[0] = 32'h00005555; req_op[0] = 3'b011;
    step();
    check1("bp_rsp_valid", rsp_valid[0], 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check32("bp_rsp_data", rsp_data[0], 32'h12345687);
      check32("bp_alu_a", alu_a[0], 32'h12345678);
      check32("bp_alu_op", 32'(alu_op[0]), 32'd0);
      check1("bp_req_ready", req_ready[0], 1'b0);
      check1("bp_busy", busy[0], 1'b1);
    end
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;
    check1("bp_idle_ready", req_ready[0], 1'b1);
    check1("bp_idle_busy", busy[0], 1'b0);
    check32("bp_alu_a_not_yet", alu_a[0], 32'h12345678);
    step();
    req_valid[0] = 1'b0;
    check32("bp_new_alu_a", alu_a[0], 32'hAAAA0000);
    check1("bp_new_busy", busy[0], 1'b1);
    step();
    check32("bp_new_rsp_data", rsp_data[0], 32'hAAAA5555);
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;

    // rsp_ready held high through WAIT must not cut the wait short.
    req_a[1] = 32'd100; req_b[1] = 32'd58; req_op[1] = 3'b001;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    step();
    check1("early_ready_wait1", rsp_valid[1], 1'b0);
    step();
    check1("early_ready_wait2", rsp_valid[1], 1'b0);
    step();
    check1("early_ready_resp", rsp_valid[1], 1'b1);
    check32("early_ready_data", rsp_data[1], 32'd42);
    step();
    rsp_ready[1] = 1'b0;
    check1("early_ready_idle", req_ready[1], 1'b1);

    // Reset in the middle of WAIT abandons the operation.
    req_a[1] = 32'hDEADBEEF; req_b[1] = 32'h1; req_op[1] = 3'b000;
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    check1("midrst_rsp_valid", rsp_valid[1], 1'b0);
    check1("midrst_busy", busy[1], 1'b0);
    check32("midrst_alu_a", alu_a[1], 32'd0);
    @(negedge clk) reset = 1'b0;
    step();
    check1("midrst_ready", req_ready[1], 1'b1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid[1]) pulses++;
    end
    check32("midrst_no_rsp", 32'(pulses), 32'd0);
    exp_q.push_back(32'h00000003);
    do_op(1, 32'h1, 32'h2, 3'b000, 1);

    // Random operations against the reference ALU.
    for (int i = 0; i < 30; i++) begin
      int g;
      logic [31:0] a, b;
      logic [2:0] op;
      g = int'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      op = 3'($urandom_range(0, 7));
      exp_q.push_back(alu_f(a, b, op));
      do_op(g, a, b, op, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
